// File: rtl/cam_pkg.sv
// Shared definitions for the camera frame statistics block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cam_pkg;

    localparam int CAM_BYTE_W  = 20;
    localparam int CAM_LINE_W  = 12;
    localparam int CAM_FRAME_W = 16;
    localparam int CAM_SKIP_W  = 4;

    // Frame tracking states. WAIT_VS is only used after reset, so a frame that
    // was already in progress when reset released is never counted.
    typedef enum logic [1:0] {
        ST_WAIT_VS = 2'd0,
        ST_BLANK   = 2'd1,
        ST_ACTIVE  = 2'd2
    } cam_state_t;

endpackage

// File: rtl/cam_sync_edge.sv
// Registers a pclk-synchronous strobe once and flags its rising/falling edges.
// Latency: edge flags are combinational against the registered copy (visible in
//          the same cycle the input changes, acted on at the next clock edge).
// Backpressure: none.
// Ports: i_clk/i_rst clock and async active-high reset, i_d strobe in,
//        o_rise/o_fall single-cycle edge flags.
module cam_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_d <= 1'b0;
        end else begin
            r_d <= i_d;
        end
    end

    assign o_rise = i_d & ~r_d;
    assign o_fall = ~i_d & r_d;

endmodule

// File: rtl/cam_frame_stats.sv
// Per-frame byte/line statistics for a DVP-style camera (href/vsync), with a
// decimated read trigger. Latency: totals, frame_done and read_trig appear the
// cycle after the vsync rising edge that ends a frame. Backpressure: none.
// Ports: pclk/reset clock and async active-high reset; href/vsync camera syncs;
//        arm/skip trigger enable and decimation; byte_count/line_count latched
//        totals; frame_count completed frames; frame_done/read_trig pulses;
//        len_err/ovf sticky per-frame flags; busy high while a frame is active.
module cam_frame_stats
    import cam_pkg::*;
#(
    parameter int BYTE_W  = CAM_BYTE_W,
    parameter int LINE_W  = CAM_LINE_W,
    parameter int FRAME_W = CAM_FRAME_W,
    parameter int SKIP_W  = CAM_SKIP_W
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               href,
    input  logic               vsync,
    input  logic               arm,
    input  logic [SKIP_W-1:0]  skip,
    output logic [BYTE_W-1:0]  byte_count,
    output logic [LINE_W-1:0]  line_count,
    output logic [FRAME_W-1:0] frame_count,
    output logic               frame_done,
    output logic               read_trig,
    output logic               len_err,
    output logic               ovf,
    output logic               busy
);

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_href_rise;
    logic w_href_fall;

    cam_sync_edge u_vs_edge (
        .i_clk  (pclk),
        .i_rst  (reset),
        .i_d    (vsync),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall)
    );

    cam_sync_edge u_href_edge (
        .i_clk  (pclk),
        .i_rst  (reset),
        .i_d    (href),
        .o_rise (w_href_rise),
        .o_fall (w_href_fall)
    );

    // ---------------- frame FSM ----------------
    cam_state_t r_state;
    cam_state_t w_state_nxt;
    logic       w_enter;      // BLANK -> ACTIVE this cycle
    logic       w_frame_end;  // ACTIVE -> BLANK this cycle

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT_VS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_WAIT_VS: begin
                if (w_vs_rise) begin
                    w_state_nxt = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (w_vs_fall) begin
                    w_state_nxt = ST_ACTIVE;
                    w_enter     = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_vs_rise) begin
                    w_state_nxt = ST_BLANK;
                    w_frame_end = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_VS;
            end
        endcase
    end

    // ---------------- running counters ----------------
    logic [BYTE_W-1:0] r_byte_cnt;
    logic [LINE_W-1:0] r_line_cnt;
    logic [BYTE_W-1:0] r_line_len;
    logic [BYTE_W-1:0] r_ref_len;
    logic              r_ref_vld;
    logic              r_len_err;
    logic              r_ovf;

    logic              w_active;
    logic              w_byte_inc;
    logic              w_byte_sat;
    logic [BYTE_W-1:0] w_byte_nxt;
    logic              w_line_inc;
    logic              w_line_sat;
    logic [LINE_W-1:0] w_line_nxt;
    logic [BYTE_W-1:0] w_len_nxt;

    assign w_active   = (r_state == ST_ACTIVE);
    assign w_byte_inc = w_active & href;
    assign w_byte_sat = &r_byte_cnt;
    assign w_byte_nxt = (w_byte_inc & ~w_byte_sat) ? r_byte_cnt + 1'b1 : r_byte_cnt;

    // A line closes on href falling, or at frame end if href is still high
    // (the open line is counted, including the byte sampled in that cycle).
    assign w_line_inc = w_active & (w_href_fall | (w_frame_end & href));
    assign w_line_sat = &r_line_cnt;
    assign w_line_nxt = (w_line_inc & ~w_line_sat) ? r_line_cnt + 1'b1 : r_line_cnt;

    // Current line length including this cycle. A rising href restarts it, so
    // at a falling edge it already holds the finished line's length.
    always_comb begin
        w_len_nxt = r_line_len;
        if (href) begin
            if (w_href_rise) begin
                w_len_nxt = {{(BYTE_W-1){1'b0}}, 1'b1};
            end else if (~&r_line_len) begin
                w_len_nxt = r_line_len + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_byte_cnt <= '0;
            r_line_cnt <= '0;
            r_line_len <= '0;
            r_ref_len  <= '0;
            r_ref_vld  <= 1'b0;
            r_len_err  <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_enter) begin
            r_byte_cnt <= '0;
            r_line_cnt <= '0;
            r_line_len <= '0;
            r_ref_len  <= '0;
            r_ref_vld  <= 1'b0;
            r_len_err  <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_active) begin
            r_byte_cnt <= w_byte_nxt;
            r_line_cnt <= w_line_nxt;
            r_line_len <= w_len_nxt;
            if (w_line_inc) begin
                if (!r_ref_vld) begin
                    r_ref_len <= w_len_nxt;
                    r_ref_vld <= 1'b1;
                end else if (w_len_nxt != r_ref_len) begin
                    r_len_err <= 1'b1;
                end
            end
            if ((w_byte_inc & w_byte_sat) | (w_line_inc & w_line_sat)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ---------------- frame-end results ----------------
    logic [BYTE_W-1:0]  r_byte_out;
    logic [LINE_W-1:0]  r_line_out;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [SKIP_W-1:0]  r_dec;
    logic               r_frame_done;
    logic               r_read_trig;

    // r_dec counts down the frames still to skip; arm and skip are only
    // sampled here, so changes take effect at the next frame end.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_byte_out   <= '0;
            r_line_out   <= '0;
            r_frame_cnt  <= '0;
            r_dec        <= '0;
            r_frame_done <= 1'b0;
            r_read_trig  <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            r_read_trig  <= w_frame_end & arm & (r_dec == '0);
            if (w_frame_end) begin
                r_byte_out  <= w_byte_nxt;
                r_line_out  <= w_line_nxt;
                r_frame_cnt <= r_frame_cnt + 1'b1;
                r_dec       <= (r_dec == '0) ? skip : r_dec - 1'b1;
            end
        end
    end

    assign byte_count  = r_byte_out;
    assign line_count  = r_line_out;
    assign frame_count = r_frame_cnt;
    assign frame_done  = r_frame_done;
    assign read_trig   = r_read_trig;
    assign len_err     = r_len_err;
    assign ovf         = r_ovf;
    assign busy        = w_active;

endmodule

// File: tb/tb_cam_frame_stats.sv
// Bench for cam_frame_stats: a frame-level reference model plus directed frames.
// Two instances share stimulus: default widths and an 8-bit byte counter.
module tb_cam_frame_stats;

    localparam longint MAX_B20 = 1048575;
    localparam longint MAX_B8  = 255;
    localparam longint MAX_L   = 4095;

    logic        pclk = 1'b0;
    logic        reset;
    logic        href;
    logic        vsync;
    logic        arm;
    logic [3:0]  skip;

    logic [19:0] byte_count;
    logic [11:0] line_count;
    logic [15:0] frame_count;
    logic        frame_done, read_trig, len_err, ovf, busy;

    logic [7:0]  byte_count8;
    logic [11:0] line_count8;
    logic [15:0] frame_count8;
    logic        frame_done8, read_trig8, len_err8, ovf8, busy8;

    always #5 pclk = ~pclk;

    cam_frame_stats dut (
        .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .arm(arm), .skip(skip),
        .byte_count(byte_count), .line_count(line_count), .frame_count(frame_count),
        .frame_done(frame_done), .read_trig(read_trig), .len_err(len_err), .ovf(ovf),
        .busy(busy)
    );

    cam_frame_stats #(.BYTE_W(8)) dut8 (
        .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .arm(arm), .skip(skip),
        .byte_count(byte_count8), .line_count(line_count8), .frame_count(frame_count8),
        .frame_done(frame_done8), .read_trig(read_trig8), .len_err(len_err8), .ovf(ovf8),
        .busy(busy8)
    );

    // ---------------- reference model ----------------
    // phase: 0 = waiting for first vsync rise, 1 = blanking, 2 = inside a frame.
    int     m_phase, m_frames;
    longint m_bytes, m_lines, m_len, m_ref;
    bit     m_ref_vld, m_lenerr, m_pv, m_ph;
    bit     vs_up, vs_dn, h_dn;
    longint e_byte, e_byte8, e_line, e_fc;
    bit     e_done, e_trig, e_lenerr, e_ovf, e_ovf8, e_busy;

    always @(posedge pclk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_frames = 0; m_bytes = 0; m_lines = 0; m_len = 0; m_ref = 0;
            m_ref_vld = 0; m_lenerr = 0; m_pv = 0; m_ph = 0;
            e_byte = 0; e_byte8 = 0; e_line = 0; e_fc = 0;
            e_done = 0; e_trig = 0; e_lenerr = 0; e_ovf = 0; e_ovf8 = 0; e_busy = 0;
        end else begin
            vs_up  = vsync && !m_pv;
            vs_dn  = !vsync && m_pv;
            h_dn   = !href && m_ph;
            e_done = 0;
            e_trig = 0;
            if (m_phase == 2) begin
                if (href) begin
                    m_bytes++;
                    m_len++;
                end
                if (h_dn || (vs_up && href)) begin
                    m_lines++;
                    if (!m_ref_vld) begin
                        m_ref = m_len;
                        m_ref_vld = 1;
                    end else if (m_len != m_ref) begin
                        m_lenerr = 1;
                    end
                    m_len = 0;
                end
                if (vs_up) begin
                    e_byte  = (m_bytes > MAX_B20) ? MAX_B20 : m_bytes;
                    e_byte8 = (m_bytes > MAX_B8) ? MAX_B8 : m_bytes;
                    e_line  = (m_lines > MAX_L) ? MAX_L : m_lines;
                    e_trig  = arm && ((m_frames % (int'(skip) + 1)) == 0);
                    m_frames++;
                    e_fc    = m_frames % 65536;
                    e_done  = 1;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (vs_dn) begin
                    m_phase = 2; m_bytes = 0; m_lines = 0; m_len = 0;
                    m_ref_vld = 0; m_lenerr = 0;
                end
            end else if (vs_up) begin
                m_phase = 1;
            end
            e_lenerr = m_lenerr;
            e_ovf    = (m_bytes > MAX_B20) || (m_lines > MAX_L);
            e_ovf8   = (m_bytes > MAX_B8) || (m_lines > MAX_L);
            e_busy   = (m_phase == 2);
            m_pv = vsync;
            m_ph = href;
        end
    end

    // ---------------- compare process ----------------
    int     n_vec = 0;
    int     n_err = 0;
    int     lit_id = 0;
    int     done_tot = 0, trig_tot = 0, base_done = 0, base_trig = 0;
    logic [31:0] trig_mask = '0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        chk("byte_count", byte_count, e_byte);
        chk("line_count", line_count, e_line);
        chk("frame_count", frame_count, e_fc);
        chk("frame_done", frame_done, e_done);
        chk("read_trig", read_trig, e_trig);
        chk("len_err", len_err, e_lenerr);
        chk("ovf", ovf, e_ovf);
        chk("busy", busy, e_busy);
        chk("b8_byte_count", byte_count8, e_byte8);
        chk("b8_line_count", line_count8, e_line);
        chk("b8_frame_done", frame_done8, e_done);
        chk("b8_ovf", ovf8, e_ovf8);

        if (reset) begin
            trig_mask = '0;
        end else if (frame_done) begin
            done_tot++;
            if (read_trig) begin
                trig_tot++;
                if (frame_count < 16'd32) trig_mask[frame_count[4:0]] = 1'b1;
            end
        end

        case (lit_id)
            1: begin
                base_done = done_tot;
                base_trig = trig_tot;
            end
            2: begin
                chk("rst_byte", byte_count, 0);
                chk("rst_line", line_count, 0);
                chk("rst_fc", frame_count, 0);
                chk("rst_done", frame_done, 0);
                chk("rst_trig", read_trig, 0);
                chk("rst_lenerr", len_err, 0);
                chk("rst_ovf", ovf, 0);
                chk("rst_busy", busy, 0);
            end
            3: begin
                chk("two_frames_byte", byte_count, 2560);
                chk("two_frames_line", line_count, 4);
                chk("two_frames_fc", frame_count, 2);
                chk("two_frames_done_pulses", done_tot - base_done, 2);
                chk("two_frames_trig_pulses", trig_tot - base_trig, 2);
                chk("two_frames_ovf", ovf, 0);
                chk("two_frames_b8_byte", byte_count8, 255);
                chk("two_frames_b8_ovf", ovf8, 1);
            end
            4: begin
                chk("midrst_no_done", done_tot - base_done, 0);
                chk("midrst_fc", frame_count, 0);
            end
            5: begin
                chk("midrst_byte", byte_count, 2560);
                chk("midrst_line", line_count, 4);
                chk("midrst_fc_after", frame_count, 1);
                chk("midrst_done_pulses", done_tot - base_done, 1);
            end
            6: begin
                chk("skip2_done_pulses", done_tot - base_done, 6);
                chk("skip2_trig_pulses", trig_tot - base_trig, 2);
                chk("skip2_trig_frames", trig_mask, 32'h12);
                chk("skip2_fc", frame_count, 6);
            end
            7: begin
                chk("lenerr_set", len_err, 1);
                chk("lenerr_byte", byte_count, 2559);
                chk("lenerr_line", line_count, 4);
                chk("lenerr_done", frame_done, 1);
            end
            8: chk("lenerr_held", len_err, 1);
            9: begin
                chk("lenerr_cleared", len_err, 0);
                chk("lenerr_byte_held", byte_count, 2559);
            end
            10: begin
                chk("sat_b8_byte", byte_count8, 255);
                chk("sat_b8_ovf", ovf8, 1);
                chk("sat_b20_byte", byte_count, 300);
                chk("sat_b20_ovf", ovf, 0);
                chk("sat_line", line_count, 1);
            end
            11: begin
                chk("edge_byte", byte_count, 11);
                chk("edge_line", line_count, 1);
                chk("edge_done", frame_done, 1);
                chk("edge_unarmed_trig", read_trig, 0);
            end
            12: begin
                chk("zero_byte", byte_count, 0);
                chk("zero_line", line_count, 0);
                chk("zero_done", frame_done, 1);
            end
            default: ;
        endcase
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pclk);
            #2;
        end
    endtask

    task automatic lit(input int id);
        lit_id = id;
        @(negedge pclk);
        #1;
        lit_id = 0;
        @(posedge pclk);
        #2;
    endtask

    task automatic do_reset();
        href = 1'b0;
        vsync = 1'b0;
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic line(input int len, input int gap);
        href = 1'b1;
        cyc(len);
        href = 1'b0;
        cyc(gap);
    endtask

    // vsync pulse: its rising edge closes any open frame, falling edge opens one.
    task automatic vs_open();
        vsync = 1'b1;
        cyc(3);
        vsync = 1'b0;
        cyc(3);
    endtask

    task automatic frame(input int nlines, input int len);
        vs_open();
        repeat (nlines) line(len, 4);
    endtask

    initial begin
        reset = 1'b1; href = 1'b0; vsync = 1'b0; arm = 1'b0; skip = 4'd0;
        cyc(2);
        lit(2);
        reset = 1'b0;
        cyc(2);

        // two full frames, every frame triggered
        arm = 1'b1; skip = 4'd0;
        lit(1);
        frame(4, 640);
        frame(4, 640);
        vsync = 1'b1;
        cyc(2);
        lit(3);

        // reset released in the middle of an active line
        do_reset();
        lit(1);
        vs_open();
        line(640, 4);
        href = 1'b1;
        cyc(100);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(200);
        href = 1'b0;
        cyc(4);
        line(640, 4);
        vsync = 1'b1;
        cyc(1);
        lit(4);
        cyc(1);
        vsync = 1'b0;
        cyc(3);
        repeat (4) line(640, 4);
        vsync = 1'b1;
        cyc(1);
        lit(5);

        // decimation by 3; arm toggled mid-frame only matters at frame end
        do_reset();
        arm = 1'b1; skip = 4'd2;
        lit(1);
        repeat (6) begin
            frame(2, 8);
            arm = 1'b0;
            cyc(1);
            arm = 1'b1;
        end
        vsync = 1'b1;
        cyc(2);
        lit(6);
        skip = 4'd0;

        // short third line
        do_reset();
        vs_open();
        line(640, 4);
        line(640, 4);
        line(639, 4);
        line(640, 4);
        vsync = 1'b1;
        cyc(1);
        lit(7);
        lit(8);
        vsync = 1'b0;
        cyc(1);
        lit(9);

        // byte counter saturation on the 8-bit instance
        do_reset();
        frame(1, 300);
        vsync = 1'b1;
        cyc(1);
        lit(10);

        // href high in the frame-end cycle, then a zero-length frame
        do_reset();
        arm = 1'b0;
        vs_open();
        href = 1'b1;
        cyc(10);
        vsync = 1'b1;
        cyc(1);
        lit(11);
        href = 1'b0;
        cyc(2);
        vsync = 1'b0;
        cyc(1);
        vsync = 1'b1;
        cyc(1);
        lit(12);

        cyc(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cam_frame_stats.md
CAM_FRAME_STATS -- requirements
Module: cam_frame_stats

Interface
REQ-001 SHALL have parameter BYTE_W, 20, width of per-frame byte counter.
REQ-002 SHALL have parameter LINE_W, 12, width of per-frame line counter.
REQ-003 SHALL have parameter FRAME_W, 16, width of frame counter.
REQ-004 SHALL have parameter SKIP_W, 4, width of frame-decimation field.
REQ-005 SHALL have port pclk, input, 1, sole clock; camera pixel clock, rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports href (input, 1) and vsync (input, 1), camera line and frame sync, both already pclk-synchronous.
REQ-008 SHALL have port arm, input, 1, enables read_trig generation.
REQ-009 SHALL have port skip, input, SKIP_W, frame decimation: trigger on every (skip+1)-th frame.
REQ-010 SHALL have ports byte_count (output, BYTE_W) and line_count (output, LINE_W), totals latched at last frame end.
REQ-011 SHALL have port frame_count, output, FRAME_W, completed frames since reset, wraps.
REQ-012 SHALL have ports frame_done and read_trig, output, 1 each, single-cycle pulses.
REQ-013 SHALL have ports len_err and ovf, output, 1 each, sticky per-frame error flags.
REQ-014 SHALL have port busy, output, 1, high while in ACTIVE.

Function
REQ-015 SHALL register href and vsync once and detect edges from the registered copy against current input; edge latency one cycle, no further delay.
REQ-016 SHALL implement FSM WAIT_VS -> BLANK -> ACTIVE -> BLANK: WAIT_VS exits on vsync rising edge; BLANK -> ACTIVE on vsync falling edge; ACTIVE -> BLANK on vsync rising edge (frame end).
REQ-017 SHALL, in ACTIVE, increment the running byte counter each cycle href=1.
REQ-018 SHALL increment the running line counter on each href falling edge in ACTIVE; an open line at frame end counts as a line.
REQ-019 SHALL record the first line's length as reference; any later line of different length sets len_err.
REQ-020 SHALL saturate running byte and line counters at all-ones and set ovf on any saturating increment attempt.
REQ-021 SHALL, on frame end, latch running counters (including a byte sampled in that same cycle) into byte_count/line_count, pulse frame_done, increment frame_count, and present updated outputs the cycle after the vsync rising edge.
REQ-022 SHALL pulse read_trig together with frame_done only when arm=1 and the decimation counter equals 0; decimation counter counts completed frames modulo skip+1 and is reloaded from skip only at frame end.
REQ-023 SHALL clear running counters, len_err, ovf and reference length on ACTIVE entry; latched outputs hold until next frame end.
REQ-024 SHALL ignore href outside ACTIVE.
REQ-025 SHALL treat vsync toggling in consecutive cycles as legal edges (zero-length frame latches 0/0 and still pulses frame_done).
REQ-026 SHALL give arm and skip changes effect only at the next frame end.

Reset
REQ-027 SHALL on reset drive all outputs to 0, FSM to WAIT_VS, decimation counter to 0, registered syncs to 0.
REQ-028 SHALL, when reset deasserts mid-frame, discard the partial frame: no counting until a full vsync rising/falling pair has been seen.

Structure
REQ-029 SHALL place FSM state enum and default width constants in shared package cam_pkg.
REQ-030 SHALL use one sub-module cam_sync_edge (register plus rise/fall detect), instantiated for href and vsync.

Verification
REQ-031 SHALL verify: reset, then 2 frames of 4 lines x 640 href-high cycles, skip=0, arm=1 -> byte_count=2560, line_count=4, frame_done and read_trig each pulse twice, frame_count=2.
REQ-032 SHALL verify: reset released mid-ACTIVE with href toggling -> no frame_done until second vsync rising edge; first result equals full-frame totals.
REQ-033 SHALL verify: skip=2, arm=1, 6 frames -> read_trig on frames 1 and 4 only, frame_done on all 6.
REQ-034 SHALL verify: line 3 of 4 has 639 bytes -> len_err=1 at frame end, cleared on next frame's vsync falling edge.
REQ-035 SHALL verify: BYTE_W=8, one frame of 300 href cycles -> byte_count=255, ovf=1.
REQ-036 SHALL verify: href high in the vsync-rising-edge cycle with 10 prior bytes -> byte_count=11, line_count=1.
